mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter FAIR_LIMIT, default 3, the maximum number of consecutive D grants while an I request waits.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-003 The block SHALL have port proc_reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port i_mem_read, input, 1 bit: I-cache line read request, held until i_mem_ready.
REQ-005 The block SHALL have port i_mem_addr, input, [31:4]: I-cache line address.
REQ-006 The block SHALL have port i_mem_rdata, output, 128 bits: read line to the I-cache.
REQ-007 The block SHALL have port i_mem_ready, output, 1 bit: I transaction complete.
REQ-008 The block SHALL have ports d_mem_read and d_mem_write, input, 1 bit each: D-cache line read and write-back requests, held until d_mem_ready.
REQ-009 The block SHALL have port d_mem_addr, input, [31:4]: D-cache line address.
REQ-010 The block SHALL have port d_mem_wdata, input, 128 bits: D-cache write-back line.
REQ-011 The block SHALL have port d_mem_rdata, output, 128 bits: read line to the D-cache.
REQ-012 The block SHALL have port d_mem_ready, output, 1 bit: D transaction complete.
REQ-013 The block SHALL have ports mem_read and mem_write, output, 1 bit each: requests to the shared slow memory.
REQ-014 The block SHALL have ports mem_addr, output, [31:4], and mem_wdata, output, 128 bits: the shared memory address and write data.
REQ-015 The block SHALL have ports mem_rdata, input, 128 bits, and mem_ready, input, 1 bit: the shared memory response; mem_ready is a one-cycle pulse.

Function
REQ-016 The FSM SHALL have the states IDLE, GNT_I, GNT_D and RELEASE.
REQ-017 In IDLE, a pending D request (d_mem_read|d_mem_write) SHALL win over i_mem_read, unless fair_cnt==FAIR_LIMIT and i_mem_read is high; in that case I SHALL win.
REQ-018 fair_cnt SHALL count +1 on each D grant made while i_mem_read is high, SHALL clear on any I grant or when i_mem_read is low at grant time, and SHALL saturate at FAIR_LIMIT.
REQ-019 On the grant edge, the block SHALL register mem_addr, mem_wdata and the op from the winner; mem_read/mem_write SHALL assert the cycle after the request is seen in IDLE, a one-cycle arbitration latency.
REQ-020 If d_mem_read and d_mem_write are both high, the write SHALL be issued, and a read SHALL never be issued in that grant.
REQ-021 Registered memory outputs SHALL remain stable for the whole grant, independent of later requester input changes.
REQ-022 In GNT_x, mem_ready SHALL pass combinationally to the owner's x_mem_ready in the same cycle; the non-owner's ready SHALL stay 0.
REQ-023 i_mem_rdata and d_mem_rdata SHALL both be driven from mem_rdata; only the owner's ready qualifies the data.
REQ-024 On mem_ready in GNT_x, mem_read/mem_write SHALL deassert on the next edge, and the FSM SHALL move to RELEASE.
REQ-025 RELEASE SHALL last exactly one cycle and grant nothing, which guarantees that a request held until the cycle after ready is never re-issued; the FSM SHALL then return to IDLE.
REQ-026 mem_ready while in IDLE or RELEASE SHALL be ignored, and no ready SHALL be generated.
REQ-027 IDLE with no request SHALL stay in IDLE with mem_read=mem_write=0.
REQ-028 Back-to-back transactions SHALL have a minimum spacing of mem_ready -> RELEASE -> IDLE -> new mem_read, i.e. 3 edges.

Reset
REQ-029 While proc_reset is high, all state SHALL clear asynchronously: FSM=IDLE, fair_cnt=0, mem_read=mem_write=0, mem_addr=0, mem_wdata=0, i_mem_ready=d_mem_ready=0.
REQ-030 If reset is asserted mid-grant, the in-flight transaction SHALL be abandoned with no ready issued to the requester.
REQ-031 After reset deasserts, the first grant SHALL follow the normal IDLE rules.

Verification
REQ-032 I read only, addr 0x0000010, memory ready after 5 cycles with 0xA5..A5: mem_read=1 one cycle after the request, i_mem_ready=1 in the same cycle as mem_ready, i_mem_rdata=0xA5..A5, d_mem_ready=0 throughout.
REQ-033 I and D read requests raised in the same cycle: D is granted first, and I is granted 3 edges after the D mem_ready.
REQ-034 D requests held continuously with I pending, FAIR_LIMIT=3: the grant order is D,D,D,I,D; fair_cnt reads 3 before the I grant and 0 after it.
REQ-035 D write-back, addr 0x0000020, wdata 0x1234..: the registered mem_addr and mem_wdata are unchanged when d_mem_addr is changed mid-grant; mem_write drops the edge after mem_ready; no re-issue occurs during RELEASE.
REQ-036 proc_reset pulsed during GNT_D: mem_read drops immediately, no d_mem_ready is issued, and the FSM is in IDLE after release.
REQ-037 A spurious mem_ready in IDLE produces no ready output and no state change.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-port arbiter that shares one slow line-sized memory between the I-cache and D-cache.
// D normally wins, but a waiting I request is granted after FAIR_LIMIT consecutive D grants.
module mem_arbiter #(
  parameter int FAIR_LIMIT = 3
) (
  input  logic          clk,
  input  logic          proc_reset,
  input  logic          i_mem_read,
  input  logic [31:4]   i_mem_addr,
  output logic [127:0]  i_mem_rdata,
  output logic          i_mem_ready,
  input  logic          d_mem_read,
  input  logic          d_mem_write,
  input  logic [31:4]   d_mem_addr,
  input  logic [127:0]  d_mem_wdata,
  output logic [127:0]  d_mem_rdata,
  output logic          d_mem_ready,
  output logic          mem_read,
  output logic          mem_write,
  output logic [31:4]   mem_addr,
  output logic [127:0]  mem_wdata,
  input  logic [127:0]  mem_rdata,
  input  logic          mem_ready
);

  localparam int CNT_W = (FAIR_LIMIT < 1) ? 1 : $clog2(FAIR_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(FAIR_LIMIT);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GNT_I   = 2'd1,
    GNT_D   = 2'd2,
    RELEASE = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   fair_cnt_q, fair_cnt_d;
  logic               mem_read_q, mem_read_d;
  logic               mem_write_q, mem_write_d;
  logic [31:4]        mem_addr_q, mem_addr_d;
  logic [127:0]       mem_wdata_q, mem_wdata_d;
  logic               d_req_s;
  logic               i_wins_s;

  // Arbitration, grant capture and completion handling.
  always_comb begin
    state_d     = state_q;
    fair_cnt_d  = fair_cnt_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    d_req_s     = d_mem_read | d_mem_write;
    i_wins_s    = i_mem_read & (~d_req_s | (fair_cnt_q == LIMIT));

    case (state_q)
      IDLE: begin
        if (i_wins_s) begin
          state_d     = GNT_I;
          fair_cnt_d  = '0;
          mem_read_d  = 1'b1;
          mem_write_d = 1'b0;
          mem_addr_d  = i_mem_addr;
          mem_wdata_d = 128'd0;
        end else if (d_req_s) begin
          state_d     = GNT_D;
          // A simultaneous read+write is a write-back; never issue the read.
          mem_write_d = d_mem_write;
          mem_read_d  = ~d_mem_write;
          mem_addr_d  = d_mem_addr;
          mem_wdata_d = d_mem_wdata;
          if (!i_mem_read) begin
            fair_cnt_d = '0;
          end else if (fair_cnt_q != LIMIT) begin
            fair_cnt_d = fair_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
          end else begin
            fair_cnt_d = fair_cnt_q;
          end
        end else begin
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
        end
      end
      GNT_I, GNT_D: begin
        if (mem_ready) begin
          state_d     = RELEASE;
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
        end else begin
          state_d = state_q;
        end
      end
      RELEASE: begin
        // Swallows the requester's still-high request from the ready cycle.
        state_d     = IDLE;
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
      end
      default: begin
        state_d     = IDLE;
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
      end
    endcase
  end

  // State and registered memory-side request.
  always_ff @(posedge clk or posedge proc_reset) begin
    if (proc_reset) begin
      state_q     <= IDLE;
      fair_cnt_q  <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= 28'd0;
      mem_wdata_q <= 128'd0;
    end else begin
      state_q     <= state_d;
      fair_cnt_q  <= fair_cnt_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign mem_read    = mem_read_q;
  assign mem_write   = mem_write_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign i_mem_ready = (state_q == GNT_I) & mem_ready;
  assign d_mem_ready = (state_q == GNT_D) & mem_ready;
  assign i_mem_rdata = mem_rdata;
  assign d_mem_rdata = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: expected grants are queued with the stimulus and
// checked when the arbiter presents them to a behavioural slow memory.
module tb_mem_arbiter;

  logic          clk = 1'b0;
  logic          proc_reset;
  logic          i_mem_read;
  logic [31:4]   i_mem_addr;
  logic [127:0]  i_mem_rdata;
  logic          i_mem_ready;
  logic          d_mem_read;
  logic          d_mem_write;
  logic [31:4]   d_mem_addr;
  logic [127:0]  d_mem_wdata;
  logic [127:0]  d_mem_rdata;
  logic          d_mem_ready;
  logic          mem_read;
  logic          mem_write;
  logic [31:4]   mem_addr;
  logic [127:0]  mem_wdata;
  logic [127:0]  mem_rdata;
  logic          mem_ready;

  typedef struct {
    logic         is_d;
    logic         wr;
    logic [31:4]  addr;
    logic [127:0] wdata;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   w;

  mem_arbiter #(.FAIR_LIMIT(3)) dut (
    .clk(clk), .proc_reset(proc_reset),
    .i_mem_read(i_mem_read), .i_mem_addr(i_mem_addr),
    .i_mem_rdata(i_mem_rdata), .i_mem_ready(i_mem_ready),
    .d_mem_read(d_mem_read), .d_mem_write(d_mem_write),
    .d_mem_addr(d_mem_addr), .d_mem_wdata(d_mem_wdata),
    .d_mem_rdata(d_mem_rdata), .d_mem_ready(d_mem_ready),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Waits (bounded) for a memory request; w counts negedges waited.
  task automatic wait_req(output int waits);
    waits = 0;
    while (!(mem_read | mem_write) && waits < 50) begin
      @(negedge clk);
      waits++;
    end
    if (!(mem_read | mem_write)) check_eq("req_timeout", 1'b0, 1'b1);
  endtask

  // Pops the expected grant, checks it, answers after lat cycles and checks completion.
  task automatic serve(input int lat, input logic [127:0] rd, input logic perturb, output int waits);
    exp_t e;
    wait_req(waits);
    if (!(mem_read | mem_write)) return;
    if (sb.size() == 0) begin
      check_eq("sb_empty", 1'b1, 1'b0);
      return;
    end
    e = sb.pop_front();
    check_eq("op", {mem_read, mem_write}, e.wr ? 2'b01 : 2'b10);
    check_eq("addr", mem_addr, e.addr);
    if (e.wr) check_eq("wdata", mem_wdata, e.wdata);
    for (int k = 1; k < lat; k++) begin
      @(negedge clk);
      if (perturb) begin
        d_mem_addr  = ~d_mem_addr;
        d_mem_wdata = ~d_mem_wdata;
      end
      check_eq("addr_hold", mem_addr, e.addr);
      check_eq("wdata_hold", mem_wdata, e.wr ? e.wdata : mem_wdata);
      check_eq("op_hold", {mem_read, mem_write}, e.wr ? 2'b01 : 2'b10);
    end
    mem_rdata = rd;
    mem_ready = 1'b1;
    #1;
    check_eq("own_ready", e.is_d ? d_mem_ready : i_mem_ready, 1'b1);
    check_eq("other_ready", e.is_d ? i_mem_ready : d_mem_ready, 1'b0);
    check_eq("rdata", e.is_d ? d_mem_rdata : i_mem_rdata, rd);
    @(negedge clk);
    mem_ready = 1'b0;
    check_eq("req_drop", {mem_read, mem_write}, 2'b00);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] fair_exp [5];
    proc_reset  = 1'b1;
    i_mem_read  = 1'b0;
    i_mem_addr  = 28'd0;
    d_mem_read  = 1'b0;
    d_mem_write = 1'b0;
    d_mem_addr  = 28'd0;
    d_mem_wdata = 128'd0;
    mem_rdata   = 128'd0;
    mem_ready   = 1'b0;
    fair_exp    = '{128'd1, 128'd2, 128'd3, 128'd0, 128'd0};
    repeat (2) @(negedge clk);

    check_eq("rst_rd", mem_read, 1'b0);
    check_eq("rst_wr", mem_write, 1'b0);
    check_eq("rst_addr", mem_addr, 28'd0);
    check_eq("rst_wdata", mem_wdata, 128'd0);
    check_eq("rst_irdy", i_mem_ready, 1'b0);
    check_eq("rst_drdy", d_mem_ready, 1'b0);
    check_eq("rst_fair", dut.fair_cnt_q, 2'd0);
    proc_reset = 1'b0;
    @(negedge clk);

    // Single I read, 5-cycle memory.
    i_mem_read = 1'b1;
    i_mem_addr = 28'h0000010;
    sb.push_back('{1'b0, 1'b0, 28'h0000010, 128'd0});
    serve(5, {16{8'hA5}}, 1'b0, w);
    check_eq("t1_latency", w, 1);
    i_mem_read = 1'b0;
    @(negedge clk);

    // I and D together: D first, I three edges after D's ready.
    d_mem_read = 1'b1;
    d_mem_addr = 28'h0000100;
    i_mem_read = 1'b1;
    i_mem_addr = 28'h0000200;
    sb.push_back('{1'b1, 1'b0, 28'h0000100, 128'd0});
    sb.push_back('{1'b0, 1'b0, 28'h0000200, 128'd0});
    serve(3, {4{32'hDDDD_0001}}, 1'b0, w);
    check_eq("t2_d_latency", w, 1);
    d_mem_read = 1'b0;
    serve(2, {4{32'h1111_0002}}, 1'b0, w);
    check_eq("t2_i_gap", w, 2);
    i_mem_read = 1'b0;
    @(negedge clk);

    // Fairness: D held, I pending -> D,D,D,I,D.
    d_mem_read = 1'b1;
    d_mem_addr = 28'h0000300;
    i_mem_read = 1'b1;
    i_mem_addr = 28'h0000400;
    for (int k = 0; k < 5; k++) begin
      if (k == 3) sb.push_back('{1'b0, 1'b0, 28'h0000400, 128'd0});
      else        sb.push_back('{1'b1, 1'b0, 28'h0000300, 128'd0});
    end
    for (int k = 0; k < 5; k++) begin
      serve(2, {4{k}}, 1'b0, w);
      check_eq($sformatf("fair_cnt_%0d", k), dut.fair_cnt_q, fair_exp[k]);
      if (k == 3) i_mem_read = 1'b0;
    end
    d_mem_read = 1'b0;
    @(negedge clk);

    // D write-back with inputs perturbed mid-grant, request held into RELEASE.
    d_mem_write = 1'b1;
    d_mem_addr  = 28'h0000020;
    d_mem_wdata = {8{16'h1234}};
    sb.push_back('{1'b1, 1'b1, 28'h0000020, {8{16'h1234}}});
    serve(4, 128'd0, 1'b1, w);
    @(negedge clk);
    check_eq("t4_release_noissue", {mem_read, mem_write}, 2'b00);
    d_mem_write = 1'b0;
    @(negedge clk);
    check_eq("t4_idle_noissue", {mem_read, mem_write}, 2'b00);

    // Read and write together: write only.
    d_mem_read  = 1'b1;
    d_mem_write = 1'b1;
    d_mem_addr  = 28'h0000500;
    d_mem_wdata = {4{32'hCAFE_F00D}};
    sb.push_back('{1'b1, 1'b1, 28'h0000500, {4{32'hCAFE_F00D}}});
    serve(1, 128'd0, 1'b0, w);
    d_mem_read  = 1'b0;
    d_mem_write = 1'b0;
    @(negedge clk);

    // Reset during GNT_D abandons the transaction.
    d_mem_read = 1'b1;
    d_mem_addr = 28'h0000600;
    wait_req(w);
    check_eq("t6_grant", mem_read, 1'b1);
    @(negedge clk);
    proc_reset = 1'b1;
    #1;
    check_eq("t6_rd_drop", mem_read, 1'b0);
    check_eq("t6_addr_clr", mem_addr, 28'd0);
    mem_ready = 1'b1;
    #1;
    check_eq("t6_no_drdy", d_mem_ready, 1'b0);
    @(negedge clk);
    mem_ready  = 1'b0;
    d_mem_read = 1'b0;
    proc_reset = 1'b0;
    @(negedge clk);
    check_eq("t6_state_idle", dut.state_q, 2'd0);
    check_eq("t6_no_req", {mem_read, mem_write}, 2'b00);

    // First grant after reset follows normal rules.
    i_mem_read = 1'b1;
    i_mem_addr = 28'h0000700;
    sb.push_back('{1'b0, 1'b0, 28'h0000700, 128'd0});
    serve(2, {2{64'h0123_4567_89AB_CDEF}}, 1'b0, w);
    check_eq("t7_latency", w, 1);
    i_mem_read = 1'b0;
    repeat (2) @(negedge clk);

    // Spurious mem_ready in IDLE.
    mem_ready = 1'b1;
    #1;
    check_eq("t8_irdy", i_mem_ready, 1'b0);
    check_eq("t8_drdy", d_mem_ready, 1'b0);
    @(negedge clk);
    mem_ready = 1'b0;
    check_eq("t8_state", dut.state_q, 2'd0);
    check_eq("t8_no_req", {mem_read, mem_write}, 2'b00);
    check_eq("sb_drained", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
